// File: rtl/wb_source_select.sv
// Two-entry writeback FIFO that captures one of NUM_SRC source words per request
// and flags requests whose source index is out of range.
module wb_source_select #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 3,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [SEL_W-1:0]            sel,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [DATA_W-1:0]           wb_data,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic                        sel_err,
    output logic [7:0]                  err_cnt,
    input  logic                        err_clr
);

    localparam logic [SEL_W:0] NUM_SRC_C = (SEL_W + 1)'(NUM_SRC);

    logic [DATA_W-1:0] mem_data_q [2];
    logic [ADDR_W-1:0] mem_addr_q [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              sel_err_q, sel_err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              push;
    logic              pop;
    logic              sel_ok;
    logic [DATA_W-1:0] sel_data;

    assign in_ready = (count_q < 2'd2);
    assign wb_valid = (count_q != 2'd0);
    assign wb_data  = mem_data_q[head_q];
    assign wb_addr  = mem_addr_q[head_q];
    assign sel_err  = sel_err_q;
    assign err_cnt  = err_cnt_q;

    // flush wins over both sides of the FIFO, so neither push nor pop happens on it
    assign push   = in_valid && in_ready && !flush;
    assign pop    = wb_valid && wb_ready && !flush;
    assign sel_ok = ({1'b0, sel} < NUM_SRC_C);

    // Out-of-range indices match no source and fall through to zero
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if ({1'b0, sel} == (SEL_W + 1)'(k)) begin
                sel_data = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;

        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Clear first so a same-cycle bad push leaves the flag set with a count of one
        if (err_clr) begin
            sel_err_d = 1'b0;
            err_cnt_d = 8'd0;
        end
        if (push && !sel_ok) begin
            sel_err_d = 1'b1;
            if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            sel_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_addr_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
            if (push) begin
                mem_data_q[tail_q] <= sel_data;
                mem_addr_q[tail_q] <= in_addr;
            end
        end
    end

endmodule

// File: tb/tb_wb_source_select.sv
// Bench for wb_source_select: directed scenarios followed by random traffic,
// all compared against a queue-based model of the writeback buffer.
module tb_wb_source_select;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 3;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          sel;
    logic [ADDR_W-1:0]         in_addr;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [DATA_W-1:0]         wb_data;
    logic [ADDR_W-1:0]         wb_addr;
    logic                      wb_valid;
    logic                      wb_ready;
    logic                      sel_err;
    logic [7:0]                err_cnt;
    logic                      err_clr;

    int checks   = 0;
    int failures = 0;

    // Model state: pending entries packed as {data, addr}, plus error flag/count
    logic [DATA_W+ADDR_W-1:0] exp_q[$];
    bit                       m_err;
    int                       m_cnt;

    wb_source_select #(
        .DATA_W (DATA_W),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .src_data(src_data),
        .sel     (sel),
        .in_addr (in_addr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush   (flush),
        .wb_data (wb_data),
        .wb_addr (wb_addr),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .sel_err (sel_err),
        .err_cnt (err_cnt),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] src_word(input int k);
        logic [NUM_SRC*DATA_W-1:0] s;
        s = src_data;
        return s[k*DATA_W +: DATA_W];
    endfunction

    // Apply the current inputs for one clock and check everything afterwards
    task automatic drive_cycle();
        bit                do_pop;
        bit                do_push;
        bit                was_rst;
        logic [DATA_W-1:0] d;
        was_rst = !reset_n;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
        if (!reset_n) begin
            exp_q.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else if (flush) begin
            exp_q.delete();
            if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
        end else begin
            do_pop  = (exp_q.size() > 0) && wb_ready;
            do_push = in_valid && (exp_q.size() < 2);
            if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                d = (int'(sel) < NUM_SRC) ? src_word(int'(sel)) : '0;
                exp_q.push_back({d, in_addr});
                if (int'(sel) >= NUM_SRC) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("wb_valid", {63'd0, wb_valid}, {63'd0, exp_q.size() != 0});
        chk("sel_err", {63'd0, sel_err}, {63'd0, m_err});
        chk("err_cnt", {56'd0, err_cnt}, 64'(m_cnt));
        if (exp_q.size() != 0) begin
            chk("wb_data", {32'd0, wb_data}, {32'd0, exp_q[0][ADDR_W +: DATA_W]});
            chk("wb_addr", {59'd0, wb_addr}, {59'd0, exp_q[0][ADDR_W-1:0]});
        end
        if (was_rst) begin
            chk("rst_data", {32'd0, wb_data}, 64'd0);
            chk("rst_addr", {59'd0, wb_addr}, 64'd0);
        end
    endtask

    task automatic idle_inputs();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        wb_ready = 1'b0;
        sel      = '0;
        in_addr  = '0;
    endtask

    task automatic randomize_src();
        for (int k = 0; k < NUM_SRC; k++) src_data[k*DATA_W +: DATA_W] = $urandom;
    endtask

    initial begin
        idle_inputs();
        randomize_src();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a request offered: the request must be dropped
        in_valid = 1'b1;
        drive_cycle();
        drive_cycle();
        idle_inputs();
        drive_cycle();

        // One request per source index, consumer always ready
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < NUM_SRC; j++) src_data[j*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(j);
            in_valid = 1'b1;
            wb_ready = 1'b1;
            sel      = SEL_W'(k);
            in_addr  = ADDR_W'(k);
            drive_cycle();
            chk("seq_data", {32'd0, wb_data}, (k < NUM_SRC) ? 64'(32'hA000_0000 + 32'(k)) : 64'd0);
            chk("seq_addr", {59'd0, wb_addr}, 64'(k));
        end
        idle_inputs();
        wb_ready = 1'b1;
        drive_cycle();
        chk("clr_after_seq", {63'd0, sel_err}, 64'd1);

        // Fill with the consumer stalled, offer a third, then drain
        err_clr = 1'b1;
        wb_ready = 1'b0;
        drive_cycle();
        err_clr = 1'b0;
        sel = '0;
        in_valid = 1'b1;
        src_data[0 +: DATA_W] = 32'h11; in_addr = 5'd1; drive_cycle();
        src_data[0 +: DATA_W] = 32'h22; in_addr = 5'd2; drive_cycle();
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        src_data[0 +: DATA_W] = 32'h33; in_addr = 5'd3; drive_cycle();
        in_valid = 1'b0;
        wb_ready = 1'b1;
        drive_cycle();
        chk("drain_second", {32'd0, wb_data}, 64'h22);
        drive_cycle();

        // Push and pop together with one entry buffered
        wb_ready = 1'b0;
        in_valid = 1'b1;
        src_data[0 +: DATA_W] = 32'h44; drive_cycle();
        wb_ready = 1'b1;
        src_data[0 +: DATA_W] = 32'h55; drive_cycle();
        chk("pushpop_data", {32'd0, wb_data}, 64'h55);
        in_valid = 1'b0;
        drive_cycle();

        // Flush with two entries and a request offered
        wb_ready = 1'b0;
        in_valid = 1'b1;
        sel = 3'd7;
        drive_cycle();
        drive_cycle();
        flush = 1'b1;
        drive_cycle();
        chk("flush_valid", {63'd0, wb_valid}, 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;

        // Long run of out-of-range requests to saturate the counter
        wb_ready = 1'b1;
        in_valid = 1'b1;
        sel = 3'd7;
        for (int i = 0; i < 300; i++) begin
            in_addr = ADDR_W'($urandom_range(0, 31));
            drive_cycle();
        end
        chk("sat_cnt", {56'd0, err_cnt}, 64'd255);
        in_valid = 1'b0;
        err_clr = 1'b1;
        drive_cycle();
        chk("clr_cnt", {56'd0, err_cnt}, 64'd0);
        in_valid = 1'b1;
        sel = 3'd6;
        drive_cycle();
        chk("clr_and_err", {56'd0, err_cnt}, 64'd1);
        err_clr = 1'b0;
        in_valid = 1'b0;
        drive_cycle();

        // Random traffic with occasional flush, error clear and reset
        for (int i = 0; i < 3000; i++) begin
            randomize_src();
            in_valid = ($urandom_range(0, 3) != 0);
            wb_ready = ($urandom_range(0, 2) != 0);
            sel      = SEL_W'($urandom_range(0, 7));
            in_addr  = ADDR_W'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 24) == 0);
            err_clr  = ($urandom_range(0, 39) == 0);
            reset_n  = ($urandom_range(0, 59) != 0);
            drive_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_source_select.md
WB_SOURCE_SELECT -- requirements
Module: wb_source_select

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of every source word and of wb_data.
REQ-002 SHALL have parameter NUM_SRC, default 8, number of selectable sources (legal range 2..16).
REQ-003 SHALL have parameter SEL_W, default 3, width of sel; SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 SHALL have parameter ADDR_W, default 5, width of the destination register index.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 src_data  input  NUM_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-008 sel  input  SEL_W  source index for the current request.
REQ-009 in_addr  input  ADDR_W  destination register index carried with the request.
REQ-010 in_valid  input  1  request present.
REQ-011 in_ready  output  1  block can accept a request this cycle.
REQ-012 flush  input  1  discard all buffered entries.
REQ-013 wb_data  output  DATA_W  selected word at buffer head.
REQ-014 wb_addr  output  ADDR_W  register index at buffer head.
REQ-015 wb_valid  output  1  head entry valid.
REQ-016 wb_ready  input  1  consumer accepts head this cycle.
REQ-017 sel_err  output  1  sticky flag: an out-of-range sel was accepted.
REQ-018 err_cnt  output  8  saturating count of accepted out-of-range requests.
REQ-019 err_clr  input  1  clears sel_err and err_cnt.

Function
REQ-020 SHALL hold up to 2 entries in a FIFO, each {data, addr}, with occupancy count 0..2.
REQ-021 SHALL assert in_ready combinationally iff count < 2; it SHALL NOT depend on wb_ready.
REQ-022 Push: in_valid && in_ready at an edge writes {src_data[sel], in_addr} into the tail.
REQ-023 Source data SHALL be captured at the accept edge; later src_data changes SHALL NOT affect buffered entries.
REQ-024 sel >= NUM_SRC SHALL store data 0, keep in_addr, set sel_err, and increment err_cnt (saturate at 255).
REQ-025 Pop: wb_valid && wb_ready at an edge removes the head.
REQ-026 wb_valid SHALL be 1 iff count != 0; wb_data/wb_addr SHALL be registered values from the head, with no combinational path from src_data.
REQ-027 Latency: an entry accepted at edge N into an empty buffer SHALL appear on wb_valid/wb_data after edge N.
REQ-028 Push and pop at count 1: count stays 1, the new entry is head after the edge.
REQ-029 Push and pop at count 0: only the push occurs (no bypass); count becomes 1.
REQ-030 Entries SHALL leave in acceptance order; head and wb outputs SHALL hold stable while wb_valid && !wb_ready.
REQ-031 flush SHALL set count to 0 at the edge and take priority over push and pop; no entry is accepted on a flush cycle.
REQ-032 flush SHALL NOT affect sel_err or err_cnt.
REQ-033 err_clr SHALL clear sel_err and err_cnt at the edge; if an out-of-range push occurs in the same cycle, the result SHALL be sel_err=1, err_cnt=1.
REQ-034 Pointer wrap (tail/head 1 -> 0) SHALL not alter order or data.

Reset
REQ-035 reset_n=0 at an edge SHALL set count=0, wb_valid=0, wb_data=0, wb_addr=0, sel_err=0, err_cnt=0; this overrides all other inputs.
REQ-036 During reset in_ready SHALL read 1 (count=0); any in_valid in that cycle is dropped.
REQ-037 Reset while entries are buffered SHALL discard them with no pop observed.

Verification
REQ-038 Per legal sel 0..7, src k = 0xA0000000+k, in_addr=k, wb_ready=1 -> wb_data=0xA000000k, wb_addr=k one edge after accept.
REQ-039 wb_ready=0, push 0x11, 0x22, then offer 0x33 -> in_ready=0 after second push, 0x33 not taken; wb_ready=1 -> 0x11 then 0x22 out.
REQ-040 Count=1, simultaneous push 0x55 and pop -> count=1, wb_data=0x55 next cycle.
REQ-041 NUM_SRC=6, sel=7 accepted 300 times -> data 0, sel_err=1, err_cnt=255; err_clr -> both 0.
REQ-042 Two entries buffered, flush with in_valid=1 -> wb_valid=0, count=0, nothing accepted; reset_n=0 mid-stream -> all outputs 0.
